aes_req_arbiter: RTL

- Shares one AES-128 encryption core (enable/datain/key in; dataout/done out) between NUM_REQ requesters.
- Round-robin arbitration grants one requester at a time.
- Latches that requester's plaintext and key, then sequences the core: holds enable with stable operands until done, then releases it.
- Returns the ciphertext on a tagged valid/ready response port.
- Sits between the system bus adapters and the AES control/datapath.

---
 rtl/aes_arb_pkg.sv | 22 ++
 rtl/aes_rr_picker.sv | 31 +++
 rtl/aes_req_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aes_arb_pkg.sv
// Shared constants, FSM encoding and a clog2 helper for the AES shared-core arbiter.
// Combinational definitions only, so there is no latency and no backpressure.
package aes_arb_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_RESP = 2'b10
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_rr_picker.sv
// Round-robin one-hot pick: the search starts at i_ptr and wraps; purely combinational, zero latency.
// No backpressure: the grant follows i_req in the same cycle.
module aes_rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  // Scan offsets from the far end back to 0, so the candidate nearest i_ptr is written last and wins.
  always_comb begin
    int cand;
    cand    = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(i_ptr) + off) % N;
      if (i_req[cand]) begin
        o_grant       = '0;
        o_grant[cand] = 1'b1;
        o_idx         = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin share of one AES-128 core; response valid is core latency + 1 cycle after transfer. The response holds until resp_ready.
// Requests wait in IDLE only. AES_ARB_TIMEOUT_EN adds a RUN watchdog that aborts with resp_err.
module aes_req_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [AES_BLOCK_W-1:0]       resp_data,
  output logic [ID_W-1:0]              resp_id,
  output logic                         resp_err,
  output logic                         busy,
  output logic                         core_enable,
  output logic [AES_BLOCK_W-1:0]       core_datain,
  output logic [AES_BLOCK_W-1:0]       core_key,
  input  logic [AES_BLOCK_W-1:0]       core_dataout,
  input  logic                         core_done
);

  localparam int PTR_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

  if (ID_W < clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_cfg
    $error("aes_req_arbiter: unsupported parameter combination");
  end

  arb_state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic [AES_BLOCK_W-1:0] r_core_datain, r_core_key, r_resp_data;
  logic [ID_W-1:0]        r_resp_id;
  logic [NUM_REQ-1:0]     w_grant;
  logic [PTR_W-1:0]       w_idx;
  logic                   w_any;

  aes_rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

`ifdef AES_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_resp_err;
  logic       w_timeout;

  assign w_timeout = (r_wdog == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wdog <= '0;
    else if (r_state == ST_IDLE) r_wdog <= '0;
    else if (r_state == ST_RUN) r_wdog <= r_wdog + 8'd1;
  end

  assign resp_err = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (core_done) w_state_nxt = ST_RESP;
`ifdef AES_ARB_TIMEOUT_EN
        else if (w_timeout) w_state_nxt = ST_RESP;
`endif
      end
      ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (r_state == ST_IDLE) ? w_grant : '0;
    core_enable = (r_state == ST_RUN);
    resp_valid  = (r_state == ST_RESP);
    busy        = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr      <= '0;
      r_core_datain <= '0;
      r_core_key    <= '0;
      r_resp_data   <= '0;
      r_resp_id     <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      r_resp_err    <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_core_datain <= req_data[int'(w_idx)*AES_BLOCK_W +: AES_BLOCK_W];
        r_core_key    <= req_key[int'(w_idx)*AES_BLOCK_W +: AES_BLOCK_W];
        r_resp_id     <= ID_W'(w_idx);
        r_rr_ptr      <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
      end
      if (r_state == ST_RUN && core_done) begin
        r_resp_data <= core_dataout;
`ifdef AES_ARB_TIMEOUT_EN
        r_resp_err  <= 1'b0;
      end else if (r_state == ST_RUN && w_timeout) begin
        r_resp_data <= '0;
        r_resp_err  <= 1'b1;
`endif
      end
    end
  end

  assign core_datain = r_core_datain;
  assign core_key    = r_core_key;
  assign resp_data   = r_resp_data;
  assign resp_id     = r_resp_id;

endmodule
